// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus arbiter: master IDs, sizing defaults
// and the arbiter state encoding.
package bus_pkg;

    localparam int N_MASTERS   = 6;
    localparam int ID_W        = 3;
    localparam int TIMEOUT_CYC = 256;

    localparam int MST_IC   = 0;
    localparam int MST_DC   = 1;
    localparam int MST_MEM  = 2;
    localparam int MST_KBD  = 3;
    localparam int MST_DMA  = 4;
    localparam int MST_INTR = 5;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping
// modulo N. Purely combinational.
module rr_pick #(
    parameter int N    = 6,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] idx,
    output logic [N-1:0]    onehot
);

    always_comb begin
        int j;
        j      = 0;
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                idx       = ID_W'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin system-bus arbiter with registered one-hot grant and a one-cycle
// turnaround. Optional grant watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
    parameter int N_MASTERS   = bus_pkg::N_MASTERS,
    parameter int ID_W        = bus_pkg::ID_W,
    parameter int TIMEOUT_CYC = bus_pkg::TIMEOUT_CYC
) (
    input  logic                 BUS_CLK,
    input  logic                 RST,
    input  logic [N_MASTERS-1:0] BR,
    output logic [N_MASTERS-1:0] BG,
    input  logic [N_MASTERS-1:0] ACK_OUT,
    output logic                 ACK_IN,
    output logic                 BUSY,
    output logic [ID_W-1:0]      GRANT_ID,
    output logic                 ARB_TIMEOUT
);
    import bus_pkg::*;

    arb_state_e           state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      gid_q, gid_d;
    logic [N_MASTERS-1:0] bg_q, bg_d;
    logic                 ack_in_q, ack_in_d;

    logic                 pick_valid;
    logic [ID_W-1:0]      pick_idx;
    logic [N_MASTERS-1:0] pick_onehot;
    logic                 owner_ack;
    logic                 expire;

    rr_pick #(
        .N    (N_MASTERS),
        .ID_W (ID_W)
    ) u_pick (
        .req    (BR),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Masking with the live grant makes non-owner ACK bits irrelevant.
    assign owner_ack = |(ACK_OUT & bg_q);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             tmo_q;

    assign expire = (state_q == ARB_GRANT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Counter idles at zero outside GRANT, so every grant starts from zero.
    always_ff @(posedge BUS_CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= expire && !owner_ack;
            if (state_q == ARB_GRANT) cnt_q <= cnt_q + 1'b1;
            else                      cnt_q <= '0;
        end
    end

    assign ARB_TIMEOUT = tmo_q;
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT_CYC > 1);
    assign expire      = 1'b0;
    assign ARB_TIMEOUT = 1'b0;
`endif

    // The pointer advances on leaving GRANT, so RELEASE already arbitrates
    // with the released master at lowest priority.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gid_d    = gid_q;
        bg_d     = bg_q;
        ack_in_d = 1'b0;
        case (state_q)
            ARB_IDLE, ARB_RELEASE: begin
                if (pick_valid) begin
                    bg_d    = pick_onehot;
                    gid_d   = pick_idx;
                    state_d = ARB_GRANT;
                end else begin
                    bg_d    = '0;
                    gid_d   = '0;
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (owner_ack || expire) begin
                    bg_d     = '0;
                    gid_d    = '0;
                    ack_in_d = 1'b1;
                    state_d  = ARB_RELEASE;
                    ptr_d    = (gid_q == ID_W'(N_MASTERS - 1)) ? '0 : gid_q + 1'b1;
                end
            end
            default: begin
                bg_d    = '0;
                gid_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            gid_q    <= '0;
            bg_q     <= '0;
            ack_in_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gid_q    <= gid_d;
            bg_q     <= bg_d;
            ack_in_q <= ack_in_d;
        end
    end

    assign BG       = bg_q;
    assign ACK_IN   = ack_in_q;
    assign BUSY     = |bg_q;
    assign GRANT_ID = gid_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed table-driven bench for bus_rr_arbiter, plus hand sequences for
// reset-in-grant and grant hold / BUS_ARB_TIMEOUT_EN watchdog behaviour.
module tb_bus_rr_arbiter;

    localparam int N   = 6;
    localparam int IDW = 3;
    localparam int TO  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   br = '0;
    logic [N-1:0]   ack_out = '0;
    logic [N-1:0]   bg;
    logic           ack_in, busy, tmo;
    logic [IDW-1:0] gid;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .N_MASTERS   (N),
        .ID_W        (IDW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .BUS_CLK     (clk),
        .RST         (rst_n),
        .BR          (br),
        .BG          (bg),
        .ACK_OUT     (ack_out),
        .ACK_IN      (ack_in),
        .BUSY        (busy),
        .GRANT_ID    (gid),
        .ARB_TIMEOUT (tmo)
    );

    typedef struct {
        logic [5:0] br;
        logic [5:0] ack;
        logic [5:0] bg;
        logic       ai;
        logic [2:0] id;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [5:0] b, input logic [5:0] a,
                                input logic [5:0] g, input logic ai, input logic [2:0] id);
        vec_t v;
        v.br = b; v.ack = a; v.bg = g; v.ai = ai; v.id = id;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Packed view {BG, ACK_IN, BUSY, GRANT_ID, ARB_TIMEOUT}
    function automatic logic [31:0] got();
        return {20'd0, bg, ack_in, busy, gid, tmo};
    endfunction

    function automatic logic [31:0] want(input logic [5:0] g, input logic ai,
                                         input logic [2:0] id, input logic t);
        return {20'd0, g, ai, |g, id, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Rotation with BR=3F, owner ACKs on the second grant cycle
        add(6'h3F, 6'h00, 6'h01, 0, 0);
        add(6'h3F, 6'h00, 6'h01, 0, 0);
        add(6'h3F, 6'h01, 6'h00, 1, 0);
        add(6'h3F, 6'h00, 6'h02, 0, 1);
        add(6'h3F, 6'h00, 6'h02, 0, 1);
        add(6'h3F, 6'h02, 6'h00, 1, 0);
        add(6'h3F, 6'h00, 6'h04, 0, 2);
        add(6'h3F, 6'h00, 6'h04, 0, 2);
        add(6'h3F, 6'h04, 6'h00, 1, 0);
        add(6'h3F, 6'h00, 6'h08, 0, 3);
        add(6'h3F, 6'h00, 6'h08, 0, 3);
        add(6'h3F, 6'h08, 6'h00, 1, 0);
        add(6'h3F, 6'h00, 6'h10, 0, 4);
        add(6'h3F, 6'h00, 6'h10, 0, 4);
        add(6'h3F, 6'h10, 6'h00, 1, 0);
        add(6'h3F, 6'h00, 6'h20, 0, 5);
        add(6'h3F, 6'h00, 6'h20, 0, 5);
        add(6'h3F, 6'h20, 6'h00, 1, 0);
        add(6'h3F, 6'h00, 6'h01, 0, 0);
        add(6'h3F, 6'h01, 6'h00, 1, 0);
        // Handshake: foreign ACK ignored, owner ACK releases, then IDLE
        add(6'h00, 6'h00, 6'h00, 0, 0);
        add(6'h02, 6'h00, 6'h02, 0, 1);
        add(6'h02, 6'h01, 6'h02, 0, 1);
        add(6'h02, 6'h02, 6'h00, 1, 0);
        add(6'h00, 6'h00, 6'h00, 0, 0);
        add(6'h00, 6'h00, 6'h00, 0, 0);
        // Owner drops BR without ACK: bus kept; other request queued
        add(6'h10, 6'h00, 6'h10, 0, 4);
        add(6'h00, 6'h00, 6'h10, 0, 4);
        add(6'h01, 6'h00, 6'h10, 0, 4);
        add(6'h01, 6'h10, 6'h00, 1, 0);
        add(6'h01, 6'h00, 6'h01, 0, 0);
        add(6'h00, 6'h01, 6'h00, 1, 0);
        add(6'h00, 6'h00, 6'h00, 0, 0);
        // Skip/wrap: PTR=4 after master 3 releases, BR=09 -> 0 then 3
        add(6'h08, 6'h00, 6'h08, 0, 3);
        add(6'h09, 6'h08, 6'h00, 1, 0);
        add(6'h09, 6'h00, 6'h01, 0, 0);
        add(6'h09, 6'h01, 6'h00, 1, 0);
        add(6'h09, 6'h00, 6'h08, 0, 3);
        add(6'h00, 6'h08, 6'h00, 1, 0);
        add(6'h00, 6'h00, 6'h00, 0, 0);

        // Reset state with all masters requesting
        rst_n = 1'b0;
        br = 6'h3F;
        tick();
        tick();
        check("rst_bg",      32'(bg),     32'h0);
        check("rst_ack_in",  32'(ack_in), 32'h0);
        check("rst_gid",     32'(gid),    32'h0);
        check("rst_busy",    32'(busy),   32'h0);
        check("rst_timeout", 32'(tmo),    32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            br = vecs[i].br;
            ack_out = vecs[i].ack;
            tick();
            check($sformatf("row%0d", i), got(), want(vecs[i].bg, vecs[i].ai, vecs[i].id, 1'b0));
        end

        // Reset mid-GRANT: grant drops asynchronously, pointer returns to 0
        br = 6'h04;
        ack_out = 6'h00;
        tick();
        check("pre_rst_grant", got(), want(6'h04, 0, 3'd2, 0));
        rst_n = 1'b0;
        #1;
        check("async_rst_bg",     32'(bg),     32'h0);
        check("async_rst_ack_in", 32'(ack_in), 32'h0);
        check("async_rst_busy",   32'(busy),   32'h0);
        tick();
        check("rst_hold", got(), want(6'h00, 0, 3'd0, 0));
        rst_n = 1'b1;
        br = 6'h14;
        tick();
        check("post_rst_ptr0", got(), want(6'h04, 0, 3'd2, 0));
        ack_out = 6'h04;
        tick();
        check("post_rst_release", got(), want(6'h00, 1, 3'd0, 0));
        ack_out = 6'h00;
        br = 6'h00;
        tick();
        check("post_rst_idle", got(), want(6'h00, 0, 3'd0, 0));

`ifdef BUS_ARB_TIMEOUT_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        br = 6'h03;
        tick();
        check("to_grant0", got(), want(6'h01, 0, 3'd0, 0));
        for (int k = 1; k <= TO - 1; k++) begin
            tick();
            check($sformatf("to_hold0_%0d", k), got(), want(6'h01, 0, 3'd0, 0));
        end
        tick();
        check("to_revoke", got(), want(6'h00, 1, 3'd0, 1));
        tick();
        check("to_next_grant", got(), want(6'h02, 0, 3'd1, 0));
        for (int k = 1; k <= TO - 1; k++) begin
            tick();
            check($sformatf("to_hold1_%0d", k), got(), want(6'h02, 0, 3'd1, 0));
        end
        ack_out = 6'h02;
        tick();
        check("to_ack_wins", got(), want(6'h00, 1, 3'd0, 0));
        ack_out = 6'h00;
        br = 6'h00;
        tick();
        check("to_idle", got(), want(6'h00, 0, 3'd0, 0));
`else
        // Without the watchdog a grant is held indefinitely
        br = 6'h01;
        tick();
        check("hold_grant", got(), want(6'h01, 0, 3'd0, 0));
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k % 5 == 0) check($sformatf("hold_%0d", k), got(), want(6'h01, 0, 3'd0, 0));
        end
        ack_out = 6'h01;
        br = 6'h00;
        tick();
        check("hold_release", got(), want(6'h00, 1, 3'd0, 0));
        ack_out = 6'h00;
        tick();
        check("hold_idle", got(), want(6'h00, 0, 3'd0, 0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
